cv32e40px_x_result_arb: RTL and testbench

CV32E40PX_X_RESULT_ARB -- requirements
Module: cv32e40px_x_result_arb

---
 rtl/cv32e40px_x_result_arb.sv | 99 +++++++++
 tb/tb_cv32e40px_x_result_arb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cv32e40px_x_result_arb.sv
// Coprocessor result arbiter: buffers X-interface results and writes them into the
// register file in cycles the core WB stage leaves free. Define CV32E40PX_X_DUALWRITE_EN for rd/rd|1 pairs.
module cv32e40px_x_result_arb #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_result_valid_i,
  output logic        x_result_ready_o,
  input  logic [4:0]  x_result_rd_i,
  input  logic [1:0]  x_result_we_i,
  input  logic [31:0] x_result_data_i,
  input  logic [31:0] x_result_data_hi_i,
  input  logic        core_we_wb_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        sb_clr_valid_o,
  output logic [4:0]  sb_clr_addr_o,
  output logic [3:0]  occupancy_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [0:0] S_LO = 1'b0;
  localparam logic [0:0] S_HI = 1'b1;

  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [3:0]    cnt_q;
  logic [0:0]    state_q;

  logic accept, push, pop, rf_we, non_empty, head_hi;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

`ifdef CV32E40PX_X_DUALWRITE_EN
  logic          hi_q      [DEPTH];
  logic [31:0]   data_hi_q [DEPTH];

  assign head_hi   = hi_q[rptr_q];
  assign head_data = (state_q == S_HI) ? data_hi_q[rptr_q] : data_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      hi_q[wptr_q]      <= x_result_we_i[1];
      data_hi_q[wptr_q] <= x_result_data_hi_i;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^{x_result_we_i[1], x_result_data_hi_i};
  assign head_hi   = 1'b0;
  assign head_data = data_q[rptr_q];
`endif

  assign non_empty = (cnt_q != '0);
  // Ready depends only on registered occupancy (and reset), never on core_we_wb_i.
  assign x_result_ready_o = ~rst_i & (cnt_q < 4'(DEPTH));
  assign accept = x_result_valid_i & x_result_ready_o;
  assign push   = accept & x_result_we_i[0] & (x_result_rd_i != '0);
  assign rf_we  = ~rst_i & non_empty & ~core_we_wb_i;
  assign pop    = rf_we & ((state_q == S_HI) | ~head_hi);
  assign head_addr = (state_q == S_HI) ? (rd_q[rptr_q] | 5'b00001) : rd_q[rptr_q];

  always_comb begin
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (!rst_i && non_empty) begin
      rf_waddr_o = head_addr;
      rf_wdata_o = head_data;
    end
  end

  assign rf_we_o        = rf_we;
  assign sb_clr_valid_o = rf_we;
  assign sb_clr_addr_o  = rf_waddr_o;
  assign occupancy_o    = rst_i ? '0 : cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      state_q <= S_LO;
    end else begin
      if (push) begin
        rd_q[wptr_q]   <= x_result_rd_i;
        data_q[wptr_q] <= x_result_data_i;
        wptr_q         <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + 4'd1;
      else if (pop && !push) cnt_q <= cnt_q - 4'd1;
      if (rf_we) state_q <= (state_q == S_LO && head_hi) ? S_HI : S_LO;
    end
  end

endmodule

// File: tb/tb_cv32e40px_x_result_arb.sv
// Bench for cv32e40px_x_result_arb: directed vector table, dual-write sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_cv32e40px_x_result_arb;

  localparam int unsigned DEPTH = 2;
`ifdef CV32E40PX_X_DUALWRITE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, valid, ready, core, rf_we, sb_v;
  logic [4:0]  rd, waddr, sb_addr;
  logic [1:0]  we;
  logic [31:0] data, hi, wdata;
  logic [3:0]  occ;

  always #5 clk = ~clk;

  cv32e40px_x_result_arb #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .x_result_valid_i(valid), .x_result_ready_o(ready),
    .x_result_rd_i(rd), .x_result_we_i(we),
    .x_result_data_i(data), .x_result_data_hi_i(hi),
    .core_we_wb_i(core),
    .rf_we_o(rf_we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
    .sb_clr_valid_o(sb_v), .sb_clr_addr_o(sb_addr),
    .occupancy_o(occ)
  );

  typedef struct {
    logic        rst, valid;
    logic [4:0]  rd;
    logic [1:0]  we;
    logic [31:0] data, hi;
    logic        core;
    logic        e_ready, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_occ;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data, hi;
    logic        dual;
  } ent_t;

  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic r, logic v, logic [4:0] a, logic [1:0] w, logic [31:0] d,
                              logic [31:0] h, logic c, logic er, logic ew, logic [4:0] ea,
                              logic [31:0] ed, logic [3:0] eo);
    vec_t t;
    t.rst = r; t.valid = v; t.rd = a; t.we = w; t.data = d; t.hi = h; t.core = c;
    t.e_ready = er; t.e_we = ew; t.e_addr = ea; t.e_wdata = ed; t.e_occ = eo;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst = t.rst; valid = t.valid; rd = t.rd; we = t.we; data = t.data; hi = t.hi; core = t.core;
  endtask

  task automatic compare(input string name, input vec_t t);
    n_vec++;
    if (ready !== t.e_ready || rf_we !== t.e_we || sb_v !== t.e_we || waddr !== t.e_addr ||
        sb_addr !== t.e_addr || wdata !== t.e_wdata || occ !== t.e_occ) begin
      n_bad++;
      $display("FAIL %s: got ready=%b we=%b sbv=%b addr=%0d sbaddr=%0d data=%h occ=%0d; want ready=%b we=%b addr=%0d data=%h occ=%0d",
               name, ready, rf_we, sb_v, waddr, sb_addr, wdata, occ,
               t.e_ready, t.e_we, t.e_addr, t.e_wdata, t.e_occ);
    end
  endtask

  task automatic apply(input string name, input vec_t t);
    drive(t);
    #1;
    compare(name, t);
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string name, input vec_t tbl[$]);
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("%s[%0d]", name, i), tbl[i]);
  endtask

  ent_t q[$];
  bit   half;

  task automatic model_expect(inout vec_t t);
    t.e_ready = !t.rst && (q.size() < DEPTH);
    t.e_we    = !t.rst && (q.size() != 0) && !t.core;
    t.e_addr  = '0;
    t.e_wdata = '0;
    t.e_occ   = t.rst ? 4'd0 : 4'(q.size());
    if (!t.rst && q.size() != 0) begin
      t.e_addr  = half ? (q[0].rd | 5'd1) : q[0].rd;
      t.e_wdata = half ? q[0].hi : q[0].data;
    end
  endtask

  task automatic model_step(input vec_t t);
    ent_t e;
    if (t.rst) begin
      q.delete();
      half = 1'b0;
    end else begin
      if (t.e_we) begin
        if (DUAL && q[0].dual && !half) half = 1'b1;
        else begin
          void'(q.pop_front());
          half = 1'b0;
        end
      end
      if (t.valid && t.e_ready && t.we[0] && t.rd != 5'd0) begin
        e.rd = t.rd; e.data = t.data; e.hi = t.hi; e.dual = t.we[1];
        q.push_back(e);
      end
    end
  endtask

  initial begin
    vec_t tbl[$];
    vec_t dw[$];
    vec_t rs[$];
    vec_t t;

    rst = 1'b1; valid = 1'b0; rd = '0; we = '0; data = '0; hi = '0; core = 1'b0;
    @(posedge clk);
    #1;

    // rst valid rd we data hi core | ready we addr wdata occ
    tbl.push_back(mk(1, 1, 5, 2'b01, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5, 2'b01, 32'hA5A5A5A5, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 5, 32'hA5A5A5A5, 1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 2'b01, 32'h1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2, 2'b01, 32'h2, 0, 1, 1, 0, 1, 32'h1, 1));
    tbl.push_back(mk(0, 1, 3, 2'b01, 32'h3, 0, 1, 0, 0, 1, 32'h1, 2));
    tbl.push_back(mk(0, 1, 3, 2'b01, 32'h3, 0, 0, 0, 1, 1, 32'h1, 2));
    tbl.push_back(mk(0, 1, 3, 2'b01, 32'h3, 0, 0, 1, 1, 2, 32'h2, 1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 3, 32'h3, 1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 32'hDEAD, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 9, 2'b00, 32'hBEEF, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
    run_table("basic", tbl);

    // Dual-write result with the core stealing the port between the halves.
    dw.push_back(mk(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    dw.push_back(mk(0, 1, 6, 2'b11, 32'h11, 32'h22, 0, 1, 0, 0, 0, 0));
    dw.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 6, 32'h11, 1));
`ifdef CV32E40PX_X_DUALWRITE_EN
    dw.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 1, 0, 7, 32'h22, 1));
    dw.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 7, 32'h22, 1));
    dw.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
`else
    dw.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0));
    dw.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
`endif
    run_table("dual", dw);

    // Reset after the low half is written: the rd|1 write must never appear.
    rs.push_back(mk(0, 1, 6, 2'b11, 32'h11, 32'h22, 0, 1, 0, 0, 0, 0));
    rs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 6, 32'h11, 1));
    rs.push_back(mk(1, 1, 8, 2'b01, 32'h5, 0, 0, 0, 0, 0, 0, 0));
    rs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
    rs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
    run_table("rst_hi", rs);

    q.delete();
    half = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      t.rst   = (i == 0) || ($urandom_range(0, 63) == 0);
      t.valid = $urandom_range(0, 1);
      t.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      t.we    = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      t.data  = $urandom;
      t.hi    = $urandom;
      t.core  = ($urandom_range(0, 9) < 4);
      drive(t);
      #1;
      model_expect(t);
      compare($sformatf("rand[%0d]", i), t);
      @(posedge clk);
      model_step(t);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
